// File: rtl/clock_step_controller.sv
// clock_step_controller
// Front-panel execution controller for the 8-bit Machine. Converts run / step /
// halt requests into a clock-enable (cpu_ce) and a stretched reset (cpu_reset),
// giving hardware the same free-run / single-step control a bench gets by
// toggling clk.
//
// Parameters:
//   DIV_W     width of the run-rate divider input
//   RST_HOLD  clk cycles cpu_reset stays high after reset deasserts (>=1)
//   CNT_W     width of the executed-cycle counter
//
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   run_req      level, request free-run
//   step_req     single-step request, rising edge only
//   halt_req     level, force halt (beats run_req)
//   div          run rate: one cpu_ce every div+1 clk cycles (latched on RUN entry)
//   cpu_halt     Machine has executed HLT
//   cpu_ce       Machine clock-enable
//   cpu_reset    registered reset to the Machine
//   state        00 HOLD, 01 HALTED, 10 STEP, 11 RUN
//   cycle_count  number of cpu_ce cycles issued (wraps)
//
// Optional feature, macro STEP_CTRL_BREAKPOINT_EN:
//   bp_en, bp_cycle (in), bp_hit (out). While running, a cpu_ce that makes
//   cycle_count equal bp_cycle is the last one issued; bp_hit is sticky until
//   the next entry to RUN or STEP.
module clock_step_controller #(
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned RST_HOLD = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic [DIV_W-1:0] div,
  input  logic             cpu_halt,
`ifdef STEP_CTRL_BREAKPOINT_EN
  input  logic             bp_en,
  input  logic [CNT_W-1:0] bp_cycle,
  output logic             bp_hit,
`endif
  output logic             cpu_ce,
  output logic             cpu_reset,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    S_HOLD   = 2'b00,
    S_HALTED = 2'b01,
    S_STEP   = 2'b10,
    S_RUN    = 2'b11
  } state_e;

  localparam int unsigned HOLD_W = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD);

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               step_q;
  logic               cpu_reset_q, cpu_reset_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic               bp_hit_q, bp_hit_d;
  logic               step_edge;
  logic               ce;

  // Registers-only decode so the Machine never sees a glitchy enable.
  assign ce        = (state_q == S_STEP) || ((state_q == S_RUN) && (div_cnt_q == div_q));
  assign step_edge = step_req & ~step_q;

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    div_cnt_d     = div_cnt_q;
    div_d         = div_q;
    bp_hit_d      = bp_hit_q;
    cycle_count_d = cycle_count_q + CNT_W'(ce);

    case (state_q)
      S_HOLD: begin
        if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) begin
          state_d = S_HALTED;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      S_HALTED: begin
        if (step_edge) begin
          state_d  = S_STEP;
          bp_hit_d = 1'b0;
        end else if (run_req && !halt_req && !cpu_halt) begin
          state_d   = S_RUN;
          div_d     = div;
          div_cnt_d = '0;
          bp_hit_d  = 1'b0;
        end
      end
      S_STEP: begin
        state_d = S_HALTED;
      end
      S_RUN: begin
        div_cnt_d = (div_cnt_q == div_q) ? '0 : div_cnt_q + DIV_W'(1);
        // Exit is registered: a cpu_ce already high this cycle is kept.
        if (halt_req || cpu_halt || !run_req) begin
          state_d = S_HALTED;
        end
`ifdef STEP_CTRL_BREAKPOINT_EN
        if (bp_en && ce && (cycle_count_d == bp_cycle)) begin
          state_d  = S_HALTED;
          bp_hit_d = 1'b1;
        end
`endif
      end
      default: state_d = S_HOLD;
    endcase

    // Registered so it falls on the same edge the state becomes HALTED.
    cpu_reset_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_HOLD;
      hold_cnt_q    <= '0;
      div_cnt_q     <= '0;
      div_q         <= '0;
      step_q        <= 1'b0;
      cpu_reset_q   <= 1'b1;
      cycle_count_q <= '0;
      bp_hit_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      div_cnt_q     <= div_cnt_d;
      div_q         <= div_d;
      step_q        <= step_req;
      cpu_reset_q   <= cpu_reset_d;
      cycle_count_q <= cycle_count_d;
      bp_hit_q      <= bp_hit_d;
    end
  end

  assign cpu_ce      = ce;
  assign cpu_reset   = cpu_reset_q;
  assign state       = state_q;
  assign cycle_count = cycle_count_q;

`ifdef STEP_CTRL_BREAKPOINT_EN
  assign bp_hit = bp_hit_q;
`endif

endmodule
